fifo_port_scheduler: RTL and testbench



---
 rtl/fifo_port_scheduler_if.sv | 52 +++++
 rtl/fifo_port_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_fifo_port_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// fifo_port_scheduler_if
//
// Purpose : bundles the requester handshake, the consumer read handshake and
//           the FIFO pin-side signals of fifo_port_scheduler into one port.
//
// Parameters
//   NUM_REQ    number of write requesters
//   DATAWIDTH  FIFO word width
//
// Signals
//   req_valid    [NUM_REQ]            requester i presents a word
//   req_data     [NUM_REQ*DATAWIDTH]  word of requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_last     [NUM_REQ]            requester i's word is the last of its burst
//   req_ready    [NUM_REQ]            requester i's word is written this cycle
//   grant        [NUM_REQ]            registered one-hot write-side owner
//   rd_req                            consumer asks for one word
//   rd_valid                          FIFO data_out holds the requested word
//   fifo_we / fifo_re / fifo_data_in  to the FIFO
//   fifo_full / fifo_empty            from the FIFO
//
// Modports
//   master : the scheduler side
//   slave  : requesters, consumer and FIFO seen as one environment
// ---------------------------------------------------------------------------
interface fifo_port_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATAWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           grant;
    logic                         rd_req;
    logic                         rd_valid;
    logic                         fifo_we;
    logic                         fifo_re;
    logic [DATAWIDTH-1:0]         fifo_data_in;
    logic                         fifo_full;
    logic                         fifo_empty;

    modport master (
        input  req_valid, req_data, req_last, rd_req, fifo_full, fifo_empty,
        output req_ready, grant, rd_valid, fifo_we, fifo_re, fifo_data_in
    );

    modport slave (
        output req_valid, req_data, req_last, rd_req, fifo_full, fifo_empty,
        input  req_ready, grant, rd_valid, fifo_we, fifo_re, fifo_data_in
    );
endinterface

// File: rtl/fifo_port_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_port_scheduler
//
// Purpose : shares one single-ported FIFO between NUM_REQ write requesters
//           and one read consumer.  Every cycle it decides whether the FIFO
//           slot is used for a read or a write.  The write side is owned by
//           one requester at a time, chosen round-robin, for a burst of at
//           most MAX_BURST accepted words.
//
// Parameters
//   NUM_REQ    write requesters (2..8)
//   DATAWIDTH  word width, equal to the FIFO's
//   MAX_BURST  words accepted per grant (1..15)
//
// Ports
//   clk  rising-edge clock shared with the FIFO
//   rst  asynchronous active-high reset
//   bus  fifo_port_scheduler_if.master (requesters, consumer, FIFO pins)
//
// Build option
//   FIFO_SCHED_RD_PRIO_EN  when defined, a possible read always wins the
//                          slot; otherwise read and write alternate on
//                          contended cycles.
// ---------------------------------------------------------------------------
module fifo_port_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_port_scheduler_if.master  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_next;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 pick_found;
    logic [CNT_W-1:0]     burst_cnt_q;
    logic                 prio;
    logic                 rd_valid_q;

    logic                 own_valid;
    logic                 own_last;
    logic                 last_beat;
    logic                 wr_poss;
    logic                 rd_poss;
    logic                 wr_go;
    logic                 rd_go;
    logic                 burst_done;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // grant_q is only non-zero in BURST, so masking with it already
    // restricts these to the owner's signals.
    assign own_valid = |(grant_q & bus.req_valid);
    assign own_last  = |(grant_q & bus.req_last);

    assign wr_poss = own_valid & ~bus.fifo_full;
    assign rd_poss = bus.rd_req & ~bus.fifo_empty;

    // prio=0: write takes a contended slot, prio=1: read takes it.
    assign wr_go = wr_poss & (~rd_poss | ~prio);
    assign rd_go = rd_poss & (~wr_poss | prio);

    assign last_beat  = own_last | (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    // An owner that drops req_valid gives up the grant even while stalled.
    assign burst_done = (state_q == BURST) & (~own_valid | (wr_go & last_beat));

    assign rr_next = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = BURST;
            BURST:   if (burst_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic.  Gated by rst so an asserted reset silences the FIFO
    // pins immediately, including the read path that does not depend on
    // any register.
    always_comb begin
        bus.fifo_we      = 1'b0;
        bus.fifo_re      = 1'b0;
        bus.req_ready    = '0;
        bus.fifo_data_in = '0;
        if (!rst) begin
            bus.fifo_we   = wr_go;
            bus.fifo_re   = rd_go;
            bus.req_ready = wr_go ? grant_q : '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) begin
                    bus.fifo_data_in = bus.req_data[i*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

    // Grant, round-robin pointer and burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= '0;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (pick_found) begin
                grant_q     <= NUM_REQ'(1) << pick_idx;
                gnt_idx_q   <= pick_idx;
                burst_cnt_q <= '0;
            end
        end else begin
            if (wr_go) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
            if (burst_done) begin
                grant_q  <= '0;
                rr_ptr_q <= rr_next;
            end
        end
    end

`ifdef FIFO_SCHED_RD_PRIO_EN
    assign prio = 1'b1;
`else
    // Fairness toggle: flips after every cycle in which both a read and a
    // write were possible, so sustained contention alternates 1:1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (wr_poss && rd_poss) begin
            prio <= ~prio;
        end
    end
`endif

    // FIFO data_out is registered, so the word is there one cycle after re.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_go;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_port_scheduler
//
// Drives fifo_port_scheduler with directed and random traffic against a
// small FIFO occupancy emulator.  A behavioural model predicts each cycle's
// grant / we / re / rd_valid and the words to be written; those predictions
// are queued and a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_fifo_port_scheduler;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int IW   = $clog2(N);

`ifdef FIFO_SCHED_RD_PRIO_EN
    localparam bit RD_FIXED = 1'b1;
`else
    localparam bit RD_FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]  grant;
        logic          we;
        logic          re;
        logic          rdv;
        logic [N-1:0]  ready;
        logic [DW-1:0] data;
    } rec_t;

    typedef struct packed {
        logic [N-1:0]  ready;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_port_scheduler_if #(.NUM_REQ(N), .DATAWIDTH(DW)) bus ();

    fifo_port_scheduler #(
        .NUM_REQ  (N),
        .DATAWIDTH(DW),
        .MAX_BURST(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO occupancy emulator ----------------
    int   fcount = 0;
    int   fdepth = 8;
    int   pre_n  = 0;
    logic pre_go = 1'b0;

    assign bus.fifo_full  = (fcount >= fdepth);
    assign bus.fifo_empty = (fcount == 0);

    always @(posedge clk) begin
        if (pre_go) fcount <= pre_n;
        else if (bus.fifo_re && fcount > 0) fcount <= fcount - 1;
        else if (bus.fifo_we && fcount < fdepth) fcount <= fcount + 1;
    end

    // ---------------- bookkeeping ----------------
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    rec_t exp_q[$];
    wr_t  wr_q[$];
    rec_t mon_e;
    wr_t  mon_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no expectation queued at t=%0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_cnt   = 0;
    int m_rr    = 0;
    bit m_rdwin = 1'b0;
    bit m_prev_r = 1'b0;
    bit m_acc   = 1'b0;

    task automatic model_reset();
        m_owner  = -1;
        m_cnt    = 0;
        m_rr     = 0;
        m_rdwin  = RD_FIXED;
        m_prev_r = 1'b0;
        m_acc    = 1'b0;
    endtask

    // Drives one cycle of stimulus, queues the model's prediction, then
    // advances to 1 time unit after the next rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic rd);
        logic [N*DW-1:0] d;
        logic [N-1:0]    gmask;
        logic [DW-1:0]   gdata;
        logic            full, empty, wposs, rposs, w, r;
        rec_t            rec;
        wr_t             wr;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom();
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.rd_req    = rd;
        full  = (fcount >= fdepth);
        empty = (fcount == 0);
        gmask = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (i == m_owner) begin
                gmask[i] = 1'b1;
                gdata    = d[i*DW +: DW];
            end
        end
        wposs = ((gmask & v) != '0) && !full;
        rposs = rd && !empty;
        if (wposs && rposs) begin
            r = m_rdwin;
            w = !m_rdwin;
            if (!RD_FIXED) m_rdwin = !m_rdwin;
        end else begin
            w = wposs;
            r = rposs;
        end
        rec.grant = gmask;
        rec.we    = w;
        rec.re    = r;
        rec.rdv   = m_prev_r;
        rec.ready = w ? gmask : '0;
        rec.data  = gdata;
        exp_q.push_back(rec);
        if (w) begin
            wr.ready = gmask;
            wr.data  = gdata;
            wr_q.push_back(wr);
        end
        m_prev_r = r;
        m_acc    = w;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (m_owner < 0 && v[c[IW-1:0]]) begin
                    m_owner = c;
                    m_cnt   = 0;
                end
            end
        end else if (((gmask & v) == '0) ||
                     (w && (((gmask & l) != '0) || (m_cnt + 1 == MAXB)))) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
        end else if (w) begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n);
        pre_n  = n;
        pre_go = 1'b1;
        cycle('0, '0, 1'b0);
        pre_go = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                fail_now("cycle_record");
            end else begin
                mon_e = exp_q.pop_front();
                check("grant",        64'(bus.grant),        64'(mon_e.grant));
                check("fifo_we",      64'(bus.fifo_we),      64'(mon_e.we));
                check("fifo_re",      64'(bus.fifo_re),      64'(mon_e.re));
                check("rd_valid",     64'(bus.rd_valid),     64'(mon_e.rdv));
                check("req_ready",    64'(bus.req_ready),    64'(mon_e.ready));
                check("fifo_data_in", 64'(bus.fifo_data_in), 64'(mon_e.data));
            end
            check("we_re_exclusive", 64'(bus.fifo_we & bus.fifo_re), 64'(0));
            if (bus.fifo_we) begin
                if (wr_q.size() == 0) begin
                    fail_now("write_word");
                end else begin
                    mon_w = wr_q.pop_front();
                    check("write_word",  64'(bus.fifo_data_in), 64'(mon_w.data));
                    check("write_owner", 64'(bus.req_ready),    64'(mon_w.ready));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sent;
        int guard;
        logic [N-1:0] v;
        logic [N-1:0] l;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.rd_req    = 1'b0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_grant",     64'(bus.grant),        64'(0));
        check("rst_we",        64'(bus.fifo_we),      64'(0));
        check("rst_re",        64'(bus.fifo_re),      64'(0));
        check("rst_ready",     64'(bus.req_ready),    64'(0));
        check("rst_rd_valid",  64'(bus.rd_valid),     64'(0));
        check("rst_data_in",   64'(bus.fifo_data_in), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // All requesters streaming without last: grants 0,1,2,3,0, 4 words each
        fdepth = 64;
        repeat (26) cycle(4'b1111, 4'b0000, 1'b0);

        // Requester 2 sends a 3-word burst, then 0 and 2 compete
        preload(0);
        fdepth = 8;
        sent = 0;
        repeat (10) begin
            v = (sent < 3) ? 4'b0100 : 4'b0000;
            l = (sent == 2) ? 4'b0100 : 4'b0000;
            cycle(v, l, 1'b0);
            if (m_acc) sent++;
        end
        repeat (12) cycle(4'b0101, 4'b0000, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0000, 1'b0);

        // Nearly full FIFO: one write, stall on full, then reads release it
        preload(7);
        repeat (8) cycle(4'b0010, 4'b0000, 1'b0);
        repeat (10) cycle(4'b0010, 4'b0000, 1'b1);

        // Sustained contention with the FIFO half full
        preload(4);
        repeat (30) cycle(4'b1111, 4'b0000, 1'b1);

        // Owner drops req_valid mid-burst
        preload(0);
        repeat (3) begin
            repeat (3) cycle(4'b1111, 4'b0000, 1'b0);
            v = 4'b1111;
            for (int i = 0; i < N; i++) if (i == m_owner) v[i] = 1'b0;
            cycle(v, 4'b0000, 1'b0);
            repeat (2) cycle(4'b1111, 4'b0000, 1'b0);
        end

        // Random traffic
        preload(3);
        repeat (300) begin
            v = N'($urandom());
            l = N'($urandom() & $urandom() & $urandom());
            cycle(v, l, ($urandom_range(0, 2) != 0));
        end

        // Reset during the second word of a burst
        repeat (2) cycle(4'b0000, 4'b0000, 1'b0);
        preload(0);
        guard = 0;
        while (!(m_owner >= 0 && m_cnt == 1) && guard < 20) begin
            cycle(4'b1111, 4'b0000, 1'b0);
            guard++;
        end
        check("reached_second_word", 64'(m_cnt), 64'(1));
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b0000;
        bus.rd_req    = 1'b0;
        #2;
        check("second_word_we", 64'(bus.fifo_we), 64'((m_owner >= 0 && fcount < fdepth) ? 1 : 0));
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("midrst_we",      64'(bus.fifo_we),      64'(0));
        check("midrst_re",      64'(bus.fifo_re),      64'(0));
        check("midrst_ready",   64'(bus.req_ready),    64'(0));
        check("midrst_grant",   64'(bus.grant),        64'(0));
        check("midrst_data_in", 64'(bus.fifo_data_in), 64'(0));
        @(posedge clk);
        #1;
        check("midrst_rd_valid", 64'(bus.rd_valid), 64'(0));
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        wr_q.delete();
        mon_en = 1'b1;
        repeat (12) cycle(4'b1111, 4'b0000, 1'b0);

        mon_en = 1'b0;
        check("records_drained", 64'(exp_q.size()), 64'(0));
        check("writes_drained",  64'(wr_q.size()),  64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
